// File: rtl/led_display_pkg.sv
// Shared types and LED pattern helpers for the whack-a-mole LED feedback display.
package led_display_pkg;

  // Upper bound on LED count that the pattern helpers can build.
  localparam int MAX_LEDS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    WRONG = 2'd2
  } state_e;

  // A position outside [0, width) lights nothing rather than wrapping.
  function automatic logic [MAX_LEDS-1:0] onehot(input int pos, input int width);
    logic [MAX_LEDS-1:0] r;
    r = '0;
    if (pos >= 0 && pos < width && pos < MAX_LEDS) begin
      r = {{(MAX_LEDS-1){1'b0}}, 1'b1} << pos;
    end
    return r;
  endfunction

  function automatic logic [MAX_LEDS-1:0] all_on(input int width);
    logic [MAX_LEDS-1:0] r;
    if (width >= MAX_LEDS) begin
      r = '1;
    end else if (width <= 0) begin
      r = '0;
    end else begin
      r = {MAX_LEDS{1'b1}} >> (MAX_LEDS - width);
    end
    return r;
  endfunction

  function automatic logic [MAX_LEDS-1:0] all_off(input int width);
    logic [MAX_LEDS-1:0] r;
    r = '0;
    if (width < 0) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_feedback_display_blink_timer.sv
// Half-period counter, ON/OFF phase and half-period count for blink sequences.
// o_next_on is the phase value that takes effect on the coming edge.
module blink_timer #(
  parameter int BLINK_HALF = 12_500_000,
  parameter int NUM_BLINKS = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_run,
  input  logic i_seq,
  output logic o_next_on,
  output logic o_done
);

  localparam int CNT_W  = $clog2(BLINK_HALF + 1);
  localparam int HALF_W = $clog2(2 * NUM_BLINKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * NUM_BLINKS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic              wrap;

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    phase_d = phase_q;
    o_done  = 1'b0;
    if (i_restart) begin
      cnt_d   = '0;
      half_d  = '0;
      phase_d = 1'b1;
    end else if (i_run) begin
      if (wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        // Half-periods only count while a verdict sequence plays; idle blinking free-runs.
        if (i_seq) begin
          if (half_q == HALF_LAST) begin
            half_d = '0;
            o_done = 1'b1;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end

  assign o_next_on = phase_d;

endmodule

// File: rtl/led_feedback_display.sv
// LED feedback driver: idle mole display, RIGHT/WRONG blink sequences with pre-emption.
// Define LED_FEEDBACK_DISPLAY_MOLE_BLINK_EN to blink the idle mole LED instead of holding it on.
module led_feedback_display
  import led_display_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int POS_W      = $clog2(NUM_LEDS),
  parameter int BLINK_HALF = 12_500_000,
  parameter int NUM_BLINKS = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [POS_W-1:0]    i_user_guess,
  input  logic [POS_W-1:0]    i_mole_position,
  input  logic                i_user_right,
  input  logic                i_user_wrong,
  output logic [NUM_LEDS-1:0] leds,
  output logic                o_busy
);

`ifdef LED_FEEDBACK_DISPLAY_MOLE_BLINK_EN
  localparam logic IDLE_BLINK = 1'b1;
`else
  localparam logic IDLE_BLINK = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [POS_W-1:0]    guess_q, guess_d;
  logic [POS_W-1:0]    cap_mole_q, cap_mole_d;
  logic [POS_W-1:0]    mole_q;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [NUM_LEDS-1:0] oh_guess, oh_cap, oh_live, ones, zeros;
  logic                pulse, in_seq, restart, run, next_on, done;

  assign pulse   = i_user_right | i_user_wrong;
  assign in_seq  = (state_q != IDLE);
  // Moving the mole while idle restarts the idle blink in its ON phase.
  assign restart = pulse | (IDLE_BLINK && !in_seq && (i_mole_position != mole_q));
  assign run     = in_seq | IDLE_BLINK;

  blink_timer #(
    .BLINK_HALF(BLINK_HALF),
    .NUM_BLINKS(NUM_BLINKS)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(restart),
    .i_run    (run),
    .i_seq    (in_seq),
    .o_next_on(next_on),
    .o_done   (done)
  );

  always_comb begin
    state_d = state_q;
    if (i_user_right) begin
      state_d = RIGHT;
    end else if (i_user_wrong) begin
      state_d = WRONG;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  assign guess_d    = pulse ? i_user_guess    : guess_q;
  assign cap_mole_d = pulse ? i_mole_position : cap_mole_q;

  // Patterns are built from next-state values so the LED register is the only output stage.
  always_comb begin
    oh_guess = NUM_LEDS'(onehot(int'(guess_d), NUM_LEDS));
    oh_cap   = NUM_LEDS'(onehot(int'(cap_mole_d), NUM_LEDS));
    oh_live  = NUM_LEDS'(onehot(int'(i_mole_position), NUM_LEDS));
    ones     = NUM_LEDS'(all_on(NUM_LEDS));
    zeros    = NUM_LEDS'(all_off(NUM_LEDS));
    case (state_d)
      RIGHT:   leds_d = next_on ? oh_guess : zeros;
      WRONG:   leds_d = next_on ? ones : oh_cap;
      default: leds_d = (next_on || !IDLE_BLINK) ? oh_live : zeros;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      guess_q    <= '0;
      cap_mole_q <= '0;
      mole_q     <= '0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      cap_mole_q <= cap_mole_d;
      mole_q     <= i_mole_position;
      leds_q     <= leds_d;
    end
  end

  assign leds   = leds_q;
  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_feedback_display.sv
// Scoreboard bench: a narrow (POS_W=3) and a wide (POS_W=4) instance against a time-based model.
module tb_led_feedback_display;

  localparam int NL      = 8;
  localparam int BH      = 4;
  localparam int NB      = 2;
  localparam int SEQ_LEN = 2 * NB * BH;
`ifdef LED_FEEDBACK_DISPLAY_MOLE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       right = 1'b0;
  logic       wrong = 1'b0;
  logic [3:0] guess = '0;
  logic [3:0] mole = '0;
  logic [7:0] leds_n, leds_w;
  logic       busy_n, busy_w;

  always #5 clk = ~clk;

  led_feedback_display #(.NUM_LEDS(NL), .BLINK_HALF(BH), .NUM_BLINKS(NB)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_user_guess(guess[2:0]), .i_mole_position(mole[2:0]),
    .i_user_right(right), .i_user_wrong(wrong), .leds(leds_n), .o_busy(busy_n));

  led_feedback_display #(.NUM_LEDS(NL), .POS_W(4), .BLINK_HALF(BH), .NUM_BLINKS(NB)) u_wide (
    .i_clk(clk), .i_rst(rst), .i_user_guess(guess), .i_mole_position(mole),
    .i_user_right(right), .i_user_wrong(wrong), .leds(leds_w), .o_busy(busy_w));

  // kind: 0 idle, 1 right, 2 wrong; t counts cycles since the verdict edge.
  typedef struct {
    int kind; int t; int cg; int cm; int idle_t; int prev;
  } mdl_t;
  typedef struct packed {
    logic [7:0] leds;
    logic       busy;
  } exp_t;

  mdl_t mn = '{0, 0, 0, 0, 0, 0};
  mdl_t mw = '{0, 0, 0, 0, 0, 0};
  exp_t qn[$];
  exp_t qw[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [7:0] oh8(input int p);
    logic [7:0] one;
    one = 8'h01;
    return (p >= 0 && p < NL) ? (one << p) : 8'h00;
  endfunction

  task automatic mdl_step(inout mdl_t s, input bit x, input bit r, input bit w,
                          input int g, input int m, output exp_t e);
    bit on;
    if (x) begin
      s.kind = 0; s.t = 0; s.idle_t = 0; s.prev = 0;
      e = '0;
      return;
    end
    if (r || w) begin
      s.kind = r ? 1 : 2; s.t = 0; s.cg = g; s.cm = m;
    end else if (s.kind != 0) begin
      s.t++;
      if (s.t == SEQ_LEN) begin
        s.kind = 0; s.idle_t = 0;
      end
    end else begin
      s.idle_t = (m != s.prev) ? 0 : s.idle_t + 1;
    end
    s.prev = m;
    e.busy = (s.kind != 0);
    if (s.kind == 1) begin
      on = ((s.t / BH) % 2) == 0;
      e.leds = on ? oh8(s.cg) : 8'h00;
    end else if (s.kind == 2) begin
      on = ((s.t / BH) % 2) == 0;
      e.leds = on ? 8'hFF : oh8(s.cm);
    end else begin
      on = !BLINK || (((s.idle_t / BH) % 2) == 0);
      e.leds = on ? oh8(m) : 8'h00;
    end
  endtask

  task automatic step(input bit x, input bit r, input bit w, input logic [3:0] g,
                      input logic [3:0] m);
    exp_t e;
    @(negedge clk);
    rst = x; right = r; wrong = w; guess = g; mole = m;
    mdl_step(mn, x, r, w, int'(g[2:0]), int'(m[2:0]), e);
    qn.push_back(e);
    mdl_step(mw, x, r, w, int'(g), int'(m), e);
    qw.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, guess, m);
  endtask

  initial begin : monitor
    exp_t en, ew;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qn.size() != 0) begin
        en = qn.pop_front();
        ew = qw.pop_front();
        checks++;
        if ({leds_n, busy_n} !== {en.leds, en.busy}) begin
          errors++;
          $display("FAIL narrow cyc=%0d leds=%h busy=%b expected leds=%h busy=%b",
                   cyc, leds_n, busy_n, en.leds, en.busy);
        end
        checks++;
        if ({leds_w, busy_w} !== {ew.leds, ew.busy}) begin
          errors++;
          $display("FAIL wide cyc=%0d leds=%h busy=%b expected leds=%h busy=%b",
                   cyc, leds_w, busy_w, ew.leds, ew.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", qn.size());
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] m;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(4, 4'd3);
    step(1'b0, 1'b1, 1'b0, 4'd5, 4'd3);
    idle(20, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd3);
    idle(6, 4'd3);
    idle(14, 4'd6);
    step(1'b0, 1'b1, 1'b1, 4'd2, 4'd6);
    idle(18, 4'd6);
    step(1'b0, 1'b0, 1'b1, 4'd4, 4'd6);
    idle(5, 4'd6);
    step(1'b0, 1'b1, 1'b0, 4'd1, 4'd6);
    idle(18, 4'd6);
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'd6);
    idle(5, 4'd6);
    step(1'b1, 1'b0, 1'b0, 4'd7, 4'd6);
    idle(12, 4'd2);
    idle(4, 4'd9);
    step(1'b0, 1'b1, 1'b0, 4'd12, 4'd9);
    idle(17, 4'd9);
    step(1'b0, 1'b0, 1'b1, 4'd3, 4'd9);
    idle(18, 4'd9);
    m = 4'd4;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) m = 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)), m);
    end
    idle(2, m);
    @(posedge clk);
    #2;
    checks++;
    if (qn.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", qn.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
